// File: rtl/packet_loader.sv
// Stream-to-memory packet loader: writes each inbound packet from word 0 and hands it to the VM.
// Packets that overflow the buffer are discarded and counted.
module packet_loader #(
  parameter int ADDR_WIDTH     = 10,
  parameter int DATA_WIDTH     = 32,
  parameter int DROP_CNT_WIDTH = 16
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic [DATA_WIDTH-1:0]     in_data,
  input  logic                      in_valid,
  input  logic                      in_last,
  output logic                      in_ready,
  output logic [ADDR_WIDTH-1:0]     packet_mem_wr_addr,
  output logic [DATA_WIDTH-1:0]     packet_mem_wr_data,
  output logic                      packet_mem_wr_en,
  output logic                      pkt_ready,
  output logic [ADDR_WIDTH:0]       pkt_len,
  input  logic                      vm_done,
  output logic [DROP_CNT_WIDTH-1:0] drop_count
);

  typedef enum logic [1:0] {IDLE, LOAD, DROP, HOLD} state_t;

  state_t                    state_q, state_d;
  logic [ADDR_WIDTH-1:0]     idx_q, idx_d;
  logic                      ready_q, ready_d;
  logic                      wrEn_q, wrEn_d;
  logic [ADDR_WIDTH-1:0]     wrAddr_q, wrAddr_d;
  logic [DATA_WIDTH-1:0]     wrData_q, wrData_d;
  logic                      pktReady_q, pktReady_d;
  logic [ADDR_WIDTH:0]       len_q, len_d;
  logic [DROP_CNT_WIDTH-1:0] drop_q, drop_d;
  logic                      accept;

  assign accept = in_valid && ready_q;

  always_comb begin
    state_d  = state_q;
    idx_d    = idx_q;
    wrEn_d   = 1'b0;
    wrAddr_d = wrAddr_q;
    wrData_d = wrData_q;
    len_d    = len_q;
    drop_d   = drop_q;
    case (state_q)
      IDLE: begin
        if (accept) begin
          wrEn_d   = 1'b1;
          wrAddr_d = '0;
          wrData_d = in_data;
          idx_d    = ADDR_WIDTH'(1);
          if (in_last) begin
            state_d = HOLD;
            len_d   = (ADDR_WIDTH+1)'(1);
          end else begin
            state_d = LOAD;
          end
        end
      end
      LOAD: begin
        if (accept) begin
          wrEn_d   = 1'b1;
          wrAddr_d = idx_q;
          wrData_d = in_data;
          idx_d    = idx_q + ADDR_WIDTH'(1);
          // A last beat in the final slot still fits; only a non-last one overflows.
          if (in_last) begin
            state_d = HOLD;
            len_d   = {1'b0, idx_q} + (ADDR_WIDTH+1)'(1);
          end else if (idx_q == '1) begin
            state_d = DROP;
          end
        end
      end
      DROP: begin
        if (accept && in_last) begin
          state_d = IDLE;
          if (drop_q != '1) drop_d = drop_q + DROP_CNT_WIDTH'(1);
        end
      end
      HOLD: begin
        if (vm_done && pktReady_q) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
    ready_d = (state_d != HOLD);
    // Delayed one cycle behind HOLD entry so the final write has landed first.
    pktReady_d = (state_q == HOLD) && (state_d == HOLD);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= IDLE;
      idx_q      <= '0;
      ready_q    <= 1'b0;
      wrEn_q     <= 1'b0;
      wrAddr_q   <= '0;
      wrData_q   <= '0;
      pktReady_q <= 1'b0;
      len_q      <= '0;
      drop_q     <= '0;
    end else begin
      state_q    <= state_d;
      idx_q      <= idx_d;
      ready_q    <= ready_d;
      wrEn_q     <= wrEn_d;
      wrAddr_q   <= wrAddr_d;
      wrData_q   <= wrData_d;
      pktReady_q <= pktReady_d;
      len_q      <= len_d;
      drop_q     <= drop_d;
    end
  end

  assign in_ready           = ready_q;
  assign packet_mem_wr_en   = wrEn_q;
  assign packet_mem_wr_addr = wrAddr_q;
  assign packet_mem_wr_data = wrData_q;
  assign pkt_ready          = pktReady_q;
  assign pkt_len            = len_q;
  assign drop_count         = drop_q;

endmodule

// File: tb/tb_packet_loader.sv
// Randomized scoreboard bench for packet_loader: expected writes and packet lengths are queued
// per packet, and a negedge monitor pops and compares them as the DUT produces them.
module tb_packet_loader;
  localparam int AW    = 10;
  localparam int DW    = 32;
  localparam int CW    = 16;
  localparam int DEPTH = 1 << AW;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic [DW-1:0] inData = '0;
  logic          inValid = 1'b0;
  logic          inLast = 1'b0;
  logic          inReady;
  logic [AW-1:0] wrAddr;
  logic [DW-1:0] wrData;
  logic          wrEn;
  logic          pktReady;
  logic [AW:0]   pktLen;
  logic          vmDone = 1'b0;
  logic [CW-1:0] dropCount;

  int total = 0;
  int bad = 0;

  logic [DW-1:0] pktWords[$];
  int            expAddrQ[$];
  logic [DW-1:0] expDataQ[$];
  int            expLenQ[$];
  int            expDrop = 0;
  logic          prevPktReady = 1'b0;

  packet_loader #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .DROP_CNT_WIDTH(CW)) dut (
    .clk(clk), .rst(rst), .in_data(inData), .in_valid(inValid), .in_last(inLast),
    .in_ready(inReady), .packet_mem_wr_addr(wrAddr), .packet_mem_wr_data(wrData),
    .packet_mem_wr_en(wrEn), .pkt_ready(pktReady), .pkt_len(pktLen), .vm_done(vmDone),
    .drop_count(dropCount)
  );

  always #5 clk = ~clk;

  task automatic checkOutput(input string name, input longint actual, input longint expected);
    total++;
    if (actual !== expected) begin
      bad++;
      $display("[TB] FAIL %s actual=%0h expected=%0h", name, actual, expected);
    end
  endtask

  // Reference model: a packet fills words 0..DEPTH-1; longer packets are dropped and counted.
  task automatic modelPacket();
    int n = pktWords.size();
    for (int i = 0; i < n && i < DEPTH; i++) begin
      expAddrQ.push_back(i);
      expDataQ.push_back(pktWords[i]);
    end
    if (n <= DEPTH) expLenQ.push_back(n);
    else if (expDrop < (1 << CW) - 1) expDrop++;
  endtask

  task automatic makeRandomPacket(input int n);
    pktWords.delete();
    for (int i = 0; i < n; i++) pktWords.push_back($urandom);
  endtask

  task automatic acceptBeat(input logic [DW-1:0] d, input logic l);
    bit got = 0;
    bit seen;
    for (int t = 0; t < 50 && !got; t++) begin
      @(negedge clk);
      inValid = 1'b1;
      inData  = d;
      inLast  = l;
      seen    = inReady;
      @(posedge clk);
      got = seen;
    end
    if (!got) checkOutput("accept_timeout", 0, 1);
  endtask

  // gapMode: 0 back-to-back, 1 one idle cycle between beats, 2 random 0..2 idle cycles.
  task automatic applyStimulus(input int gapMode, input bit releaseHold);
    int n = pktWords.size();
    int gaps;
    modelPacket();
    for (int i = 0; i < n; i++) begin
      gaps = (gapMode == 1) ? 1 : (gapMode == 2) ? int'($urandom_range(0, 2)) : 0;
      if (i == 0) gaps = 0;
      repeat (gaps) begin
        @(negedge clk);
        inValid = 1'b0;
        inData  = $urandom;
        inLast  = 1'($urandom);
      end
      acceptBeat(pktWords[i], i == n - 1);
    end
    if (n > DEPTH) begin
      @(negedge clk);
      inValid = 1'b0;
      checkOutput("drop_count", dropCount, expDrop);
      checkOutput("ready_after_drop", inReady, 1);
      checkOutput("no_pkt_after_drop", pktReady, 0);
      return;
    end
    @(negedge clk);
    inValid = 1'b1;
    inData  = $urandom;
    inLast  = 1'($urandom);
    vmDone  = 1'b1;
    checkOutput("pkt_ready_early", pktReady, 0);
    checkOutput("ready_in_hold", inReady, 0);
    @(negedge clk);
    vmDone = 1'b0;
    checkOutput("pkt_ready_latency", pktReady, 1);
    if (!releaseHold) begin
      inValid = 1'b0;
      return;
    end
    repeat ($urandom_range(0, 2)) begin
      @(negedge clk);
      checkOutput("ready_in_hold", inReady, 0);
    end
    @(negedge clk);
    vmDone = 1'b1;
    @(negedge clk);
    vmDone  = 1'b0;
    inValid = 1'b0;
    checkOutput("pkt_ready_cleared", pktReady, 0);
    checkOutput("ready_after_done", inReady, 1);
  endtask

  task automatic checkResetOutputs();
    checkOutput("rst_in_ready", inReady, 0);
    checkOutput("rst_wr_en", wrEn, 0);
    checkOutput("rst_wr_addr", wrAddr, 0);
    checkOutput("rst_wr_data", wrData, 0);
    checkOutput("rst_pkt_ready", pktReady, 0);
    checkOutput("rst_pkt_len", pktLen, 0);
    checkOutput("rst_drop_count", dropCount, 0);
  endtask

  task automatic leaveReset();
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    checkOutput("ready_after_reset", inReady, 1);
  endtask

  // Monitor: every write and every new packet hand-off is matched against the scoreboard.
  always @(negedge clk) begin
    if (wrEn) begin
      if (expAddrQ.size() == 0) begin
        checkOutput("unexpected_write", wrAddr, -1);
      end else begin
        checkOutput("wr_addr", wrAddr, expAddrQ.pop_front());
        checkOutput("wr_data", wrData, expDataQ.pop_front());
      end
    end
    if (pktReady && !prevPktReady) begin
      if (expLenQ.size() == 0) checkOutput("unexpected_pkt", pktLen, -1);
      else checkOutput("pkt_len", pktLen, expLenQ.pop_front());
    end
    prevPktReady = pktReady;
  end

  initial begin
    #500000;
    $display("[TB] FAIL watchdog actual=timeout expected=finish");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    #3;
    checkResetOutputs();
    repeat (2) @(negedge clk);
    leaveReset();

    pktWords = '{32'hA, 32'hB, 32'hC};
    applyStimulus(0, 1);
    pktWords = '{32'h55};
    applyStimulus(0, 1);
    pktWords = '{32'h11, 32'h22, 32'h33};
    applyStimulus(1, 1);

    makeRandomPacket(DEPTH);
    applyStimulus(0, 1);
    checkOutput("drop_count_full", dropCount, 0);
    makeRandomPacket(DEPTH + 6);
    applyStimulus(0, 1);

    for (int p = 0; p < 15; p++) begin
      makeRandomPacket($urandom_range(1, 40));
      applyStimulus(2, 1);
    end

    // Reset five beats into a ten-beat packet; the fifth write is still pending and must vanish.
    makeRandomPacket(10);
    for (int i = 0; i < 5; i++) begin
      if (i < 4) begin
        expAddrQ.push_back(i);
        expDataQ.push_back(pktWords[i]);
      end
      acceptBeat(pktWords[i], 1'b0);
    end
    #1 rst = 1'b1;
    expDrop = 0;
    #1 checkResetOutputs();
    @(negedge clk);
    inValid = 1'b0;
    leaveReset();
    makeRandomPacket(2);
    applyStimulus(0, 1);
    checkOutput("drop_count_after_reset", dropCount, 0);

    // Reset while a packet is held must drop pkt_ready without waiting for a clock.
    makeRandomPacket(4);
    applyStimulus(2, 0);
    #2 rst = 1'b1;
    #1 checkOutput("rst_async_pkt_ready", pktReady, 0);
    leaveReset();

    repeat (3) @(negedge clk);
    checkOutput("writes_outstanding", expAddrQ.size(), 0);
    checkOutput("pkts_outstanding", expLenQ.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/packet_loader.md
PACKET_LOADER -- requirements
Module: packet_loader

Interface
REQ-001 Parameter ADDR_WIDTH, default 10: packet memory word address width; capacity 2^ADDR_WIDTH words.
REQ-002 Parameter DATA_WIDTH, default 32: stream and packet memory word width.
REQ-003 Parameter DROP_CNT_WIDTH, default 16: width of the dropped-packet counter.
REQ-004 Port clk, input, 1: single clock; all logic on its rising edge.
REQ-005 Port rst, input, 1: asynchronous, active-high reset.
REQ-006 Port in_data, input, DATA_WIDTH: inbound packet word.
REQ-007 Port in_valid, input, 1: in_data/in_last valid.
REQ-008 Port in_last, input, 1: current beat is the final word of its packet.
REQ-009 Port in_ready, output, 1: loader accepts a beat this cycle.
REQ-010 Port packet_mem_wr_addr, output, ADDR_WIDTH: packet memory write address.
REQ-011 Port packet_mem_wr_data, output, DATA_WIDTH: packet memory write data.
REQ-012 Port packet_mem_wr_en, output, 1: packet memory write strobe.
REQ-013 Port pkt_ready, output, 1: a complete packet is in memory and owned by the VM.
REQ-014 Port pkt_len, output, ADDR_WIDTH+1: word count of the held packet, 1..2^ADDR_WIDTH.
REQ-015 Port vm_done, input, 1: VM has finished with the held packet; single-cycle pulse.
REQ-016 Port drop_count, output, DROP_CNT_WIDTH: number of oversize packets discarded, saturating.

Function
REQ-017 A beat SHALL be accepted exactly on a rising edge with in_valid=1 and in_ready=1.
REQ-018 States SHALL be IDLE, LOAD, DROP, HOLD; in_ready=1 in IDLE, LOAD, DROP; in_ready=0 in HOLD.
REQ-019 Writes SHALL be registered: a beat accepted in cycle N SHALL drive packet_mem_wr_en=1, wr_data=that beat and wr_addr=its word index in cycle N+1; wr_en=0 in every other cycle.
REQ-020 The word index SHALL start at 0 for the first beat of each packet and increment by 1 per accepted beat.
REQ-021 IDLE: accepted beat with in_last=1 -> HOLD, pkt_len=1; with in_last=0 -> LOAD.
REQ-022 LOAD: accepted beat with in_last=1 -> HOLD, pkt_len = index+1.
REQ-023 LOAD: accepted beat at index 2^ADDR_WIDTH-1 with in_last=1 -> HOLD, pkt_len=2^ADDR_WIDTH (full buffer is legal, no wrap).
REQ-024 LOAD: accepted beat at index 2^ADDR_WIDTH-1 with in_last=0 -> DROP; that word is still written.
REQ-025 DROP: accepted beats SHALL NOT be written; accepted beat with in_last=1 -> IDLE and drop_count increments by 1, saturating at all-ones.
REQ-026 pkt_ready SHALL be registered from state==HOLD: final beat accepted in cycle N -> final write in N+1 -> pkt_ready=1 from N+2, guaranteeing the write has committed.
REQ-027 HOLD: vm_done=1 while pkt_ready=1 -> IDLE; pkt_ready=0 and in_ready=1 in the next cycle.
REQ-028 vm_done SHALL be ignored when pkt_ready=0, including cycle N+1 after entering HOLD.
REQ-029 pkt_len SHALL hold its value from entry into HOLD until the next packet reaches HOLD; it is meaningful only while pkt_ready=1.
REQ-030 in_valid/in_data/in_last SHALL be ignored when in_ready=0; in_ready SHALL NOT depend combinationally on in_valid.

Reset
REQ-031 While rst=1: state IDLE, in_ready=0, packet_mem_wr_en=0, wr_addr=0, wr_data=0, pkt_ready=0, pkt_len=0, drop_count=0.
REQ-032 Reset asserted mid-packet (LOAD or DROP) SHALL discard the partial packet without incrementing drop_count; a pending registered write SHALL be cancelled.
REQ-033 Reset asserted in HOLD SHALL deassert pkt_ready immediately (asynchronously).
REQ-034 After rst deasserts, in_ready=1 on the first clock edge's following cycle.

Verification
REQ-035 3-beat packet 0xA,0xB,0xC (last on 0xC), in_valid held high -> writes addr 0,1,2 data A,B,C on consecutive cycles; pkt_ready=1 two cycles after the 0xC acceptance; pkt_len=3.
REQ-036 While pkt_ready=1 drive in_valid=1 -> in_ready=0, no writes; pulse vm_done -> next cycle pkt_ready=0, in_ready=1, next packet writes from addr 0.
REQ-037 Single-beat packet 0x55 with in_last=1 -> one write at addr 0; pkt_len=1.
REQ-038 1024-beat packet, last on beat 1024 -> writes addr 0..1023, pkt_len=1024, drop_count=0; 1030-beat packet -> writes addr 0..1023 only, no pkt_ready, drop_count=1, loader returns to IDLE.
REQ-039 Packet with gaps (in_valid toggling 1,0,1,0,1) -> exactly 3 writes at addr 0,1,2 with no duplicates.
REQ-040 rst pulsed after 5 beats of a 10-beat packet -> all outputs reset; next 2-beat packet writes addr 0,1, pkt_len=2, drop_count=0.
